// File: rtl/serial_adder_n.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell, LSB first,
// WIDTH clocks per operation with a one-cycle done pulse on completion.
module serial_adder_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             c_reg;
    logic [CNT_W-1:0] cnt;
    logic             bit_s;
    logic             bit_c;
    logic             load;
    logic             last;

    always_comb begin
        bit_s = a_reg[0] ^ b_reg[0] ^ c_reg;
        bit_c = (a_reg[0] & b_reg[0]) | (a_reg[0] & c_reg) | (b_reg[0] & c_reg);
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                if (cnt == LAST_BIT) begin
                    last       = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Sum bits enter the top of a_reg as operand bits leave the bottom, so
    // a_reg doubles as the result shift register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            c_reg <= 1'b0;
            cnt   <= '0;
        end else if (load) begin
            a_reg <= op_a;
            b_reg <= sub ? ~op_b : op_b;
            c_reg <= sub | carry_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_reg <= {bit_s, a_reg[WIDTH-1:1]};
            b_reg <= {1'b0, b_reg[WIDTH-1:1]};
            c_reg <= bit_c;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    // c_reg holds the carry into the MSB on the last bit, giving overflow directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done      <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= last;
            if (last) begin
                sum       <= {bit_s, a_reg[WIDTH-1:1]};
                carry_out <= bit_c;
                overflow  <= c_reg ^ bit_c;
            end
        end
    end

    assign busy = (state == RUN);

endmodule
